// File: rtl/serial_parity_frame_checker.sv
// Serial LSB-first frame assembler with a trailing parity bit and parity-error flag.
// Optional saturating parity-error counter enabled by SERIAL_PARITY_ERR_CNT_EN.
module serial_parity_frame_checker #(
    parameter int unsigned DATA_W     = 8,
    parameter int unsigned ODD_PARITY = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              in_valid,
    input  logic              in_data,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_parity_err,
`ifdef SERIAL_PARITY_ERR_CNT_EN
    output logic [15:0]       err_count,
`endif
    output logic              busy
);

    localparam int unsigned      CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W);
    localparam logic             ODD_BIT  = (ODD_PARITY != 0);

    typedef enum logic [1:0] {
        S_IDLE,
        S_DATA,
        S_PARITY
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              par_q, par_d;
    logic [DATA_W-1:0] shift_q, shift_d;
    logic              valid_q, valid_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        par_d   = par_q;
        shift_d = shift_q;
        valid_d = 1'b0;
        data_d  = data_q;
        err_d   = err_q;

        if (clear) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            par_d   = 1'b0;
            shift_d = '0;
        end else if (in_valid) begin
            case (state_q)
                S_IDLE: begin
                    shift_d    = '0;
                    shift_d[0] = in_data;
                    par_d      = in_data;
                    cnt_d      = CNT_W'(1);
                    state_d    = (DATA_W == 1) ? S_PARITY : S_DATA;
                end
                S_DATA: begin
                    // Loop-based write keeps the index within the word width.
                    for (int unsigned i = 0; i < DATA_W; i++) begin
                        if (cnt_q == CNT_W'(i)) begin
                            shift_d[i] = in_data;
                        end
                    end
                    par_d = par_q ^ in_data;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_d == CNT_LAST) begin
                        state_d = S_PARITY;
                    end
                end
                S_PARITY: begin
                    valid_d = 1'b1;
                    data_d  = shift_q;
                    err_d   = ((par_q ^ in_data) != ODD_BIT);
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            par_q   <= 1'b0;
            shift_q <= '0;
            valid_q <= 1'b0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            par_q   <= par_d;
            shift_q <= shift_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end

`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [15:0] err_cnt_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            err_cnt_q <= '0;
        end else if (valid_d && err_d && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign err_count = err_cnt_q;
`endif

    assign out_valid      = valid_q;
    assign out_data       = data_q;
    assign out_parity_err = err_q;
    assign busy           = (state_q != S_IDLE);

endmodule

// File: tb/tb_serial_parity_frame_checker.sv
// Directed bench: an even-parity and an odd-parity checker share one stimulus stream.
module tb_serial_parity_frame_checker;

    logic       clk = 1'b0;
    logic       rst, clear, in_valid, in_data;
    logic       out_valid, out_parity_err, busy;
    logic [7:0] out_data;
    logic       o_valid, o_err, o_busy;
    logic [7:0] o_data;
`ifdef SERIAL_PARITY_ERR_CNT_EN
    logic [15:0] err_count, o_err_count;
`endif

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    serial_parity_frame_checker #(.DATA_W(8), .ODD_PARITY(0)) dut (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(out_valid), .out_data(out_data), .out_parity_err(out_parity_err),
`ifdef SERIAL_PARITY_ERR_CNT_EN
        .err_count(err_count),
`endif
        .busy(busy)
    );

    serial_parity_frame_checker #(.DATA_W(8), .ODD_PARITY(1)) dut_odd (
        .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_data(in_data),
        .out_valid(o_valid), .out_data(o_data), .out_parity_err(o_err),
`ifdef SERIAL_PARITY_ERR_CNT_EN
        .err_count(o_err_count),
`endif
        .busy(o_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failed++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        in_valid = 1'b1;
        in_data  = b;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        in_data  = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_data(input logic [7:0] d);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
    endtask

    initial begin
        rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_data = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", out_valid, 0);
        check("rst_data", out_data, 0);
        check("rst_err", out_parity_err, 0);
        check("rst_busy", busy, 0);
        rst = 1'b0;

        // 0xA5, parity 0, back to back
        send_bit(1'b1);
        check("a5_busy_first", busy, 1);
        send_data_rest: for (int i = 1; i < 8; i++) send_bit(((8'hA5 >> i) & 8'h01) != 0);
        check("a5_no_early_pulse", out_valid, 0);
        send_bit(1'b0);
        in_valid = 1'b0;
        check("a5p0_valid", out_valid, 1);
        check("a5p0_data", out_data, 8'hA5);
        check("a5p0_err", out_parity_err, 0);
        check("a5p0_busy", busy, 0);
        check("a5p0_odd_err", o_err, 1);
        idle(1);
        check("a5p0_pulse_one_cycle", out_valid, 0);
        check("a5p0_data_hold", out_data, 8'hA5);

        // 0xA5, parity 1
        send_data(8'hA5);
        send_bit(1'b1);
        in_valid = 1'b0;
        check("a5p1_valid", out_valid, 1);
        check("a5p1_data", out_data, 8'hA5);
        check("a5p1_err", out_parity_err, 1);
        check("a5p1_odd_err", o_err, 0);
        idle(2);

        // 0x3C (bits 0,0,1,1,1,1,0,0) with gaps 2,0,3,1,0,2,3 then 1 before parity
        send_bit(1'b0); idle(2);
        check("3c_busy_gap", busy, 1);
        check("3c_no_pulse_gap", out_valid, 0);
        send_bit(1'b0);
        send_bit(1'b1); idle(3);
        check("3c_busy_gap2", busy, 1);
        send_bit(1'b1); idle(1);
        send_bit(1'b1);
        send_bit(1'b1); idle(2);
        send_bit(1'b0); idle(3);
        send_bit(1'b0); idle(1);
        check("3c_busy_before_parity", busy, 1);
        check("3c_no_pulse_before_parity", out_valid, 0);
        send_bit(1'b0);
        in_valid = 1'b0;
        check("3c_valid", out_valid, 1);
        check("3c_data", out_data, 8'h3C);
        check("3c_err", out_parity_err, 0);
        check("3c_busy_after", busy, 0);
        idle(1);
        check("3c_single_pulse", out_valid, 0);

        // abort after 5 bits, then 0x81 parity 0
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("clr_busy", busy, 0);
        check("clr_data_kept", out_data, 8'h3C);
        send_data(8'h81);
        check("81_no_pulse_aborted", out_valid, 0);
        send_bit(1'b0);
        in_valid = 1'b0;
        check("81_valid", out_valid, 1);
        check("81_data", out_data, 8'h81);
        check("81_err", out_parity_err, 0);
        idle(1);

        // clear together with the parity bit drops the frame
        send_data(8'h00);
        clear = 1'b1;
        send_bit(1'b0);
        clear = 1'b0;
        in_valid = 1'b0;
        check("clrpar_busy", busy, 0);
        idle(1);
        check("clrpar_no_pulse", out_valid, 0);
        check("clrpar_data_kept", out_data, 8'h81);

        // 0xFF/p0 and 0x01/p0 back to back
        send_data(8'hFF);
        send_bit(1'b0);
        check("ff_valid", out_valid, 1);
        check("ff_data", out_data, 8'hFF);
        check("ff_err", out_parity_err, 0);
        send_bit(1'b1);
        check("b2b_first_bit_busy", busy, 1);
        check("b2b_pulse_ended", out_valid, 0);
        for (int i = 1; i < 8; i++) send_bit(1'b0);
        check("b2b_no_early_pulse", out_valid, 0);
        send_bit(1'b0);
        in_valid = 1'b0;
        check("01_valid", out_valid, 1);
        check("01_data", out_data, 8'h01);
        check("01_err", out_parity_err, 1);
        idle(1);

        // reset after 3 bits, then 0x00/p0
        send_bit(1'b1); send_bit(1'b1); send_bit(1'b1);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_err", out_parity_err, 0);
        check("midrst_busy", busy, 0);
        send_data(8'h00);
        check("00_no_early_pulse", out_valid, 0);
        send_bit(1'b0);
        in_valid = 1'b0;
        check("00_valid", out_valid, 1);
        check("00_data", out_data, 8'h00);
        check("00_err", out_parity_err, 0);
        check("00_odd_err", o_err, 1);
        idle(1);

`ifdef SERIAL_PARITY_ERR_CNT_EN
        check("cnt_after_rst", err_count, 0);
        for (int k = 0; k < 3; k++) begin
            send_data(8'hA5);
            send_bit(1'b1);
        end
        idle(1);
        check("cnt_three", err_count, 3);
        clear = 1'b1;
        idle(1);
        clear = 1'b0;
        check("cnt_clear_kept", err_count, 3);
        force dut.err_cnt_q = 16'hFFFF;
        idle(1);
        release dut.err_cnt_q;
        send_data(8'hA5);
        send_bit(1'b1);
        idle(1);
        check("cnt_saturate", err_count, 16'hFFFF);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

    initial begin
        #200000;
        failed++;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
